// File: rtl/stream_frame_scheduler.sv
// rtl/stream_frame_scheduler.sv - buffers a layer output stream and tags beats with frame position
// Small FIFO between producer and consumer; sequences NUM_IMG frames of WIDTH x HEIGHT per run.
module stream_frame_scheduler #(
    parameter int DWIDTH     = 32,
    parameter int CLS_W      = 4,
    parameter int WIDTH      = 56,
    parameter int HEIGHT     = 56,
    parameter int NUM_IMG    = 1,
    parameter int FIFO_DEPTH = 16,
    localparam int IMG_W     = $clog2(NUM_IMG + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DWIDTH-1:0] data_in,
    input  logic [CLS_W-1:0]  image_class,
    input  logic              data_valid_in,
    output logic              in_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic [CLS_W-1:0]  out_class,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sof,
    output logic              out_eol,
    output logic              out_eof,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [IMG_W-1:0]  img_cnt
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int TOTAL = NUM_IMG * WIDTH * HEIGHT;
    localparam int TW    = $clog2(TOTAL + 1);
    localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int EW    = CLS_W + DWIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic [TW-1:0] in_total;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [EW-1:0] head;

    logic full, push, pop, arm;
    logic last_col, last_row, last_img, final_xfer;

    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign out_valid = (count != '0);
    assign in_ready  = (state == S_RUN) && !full && (in_total < TW'(TOTAL));
    assign push      = data_valid_in && in_ready;
    assign pop       = out_valid && out_ready;
    assign arm       = (state == S_IDLE) && start;

    // Head is masked so an empty FIFO presents zeros rather than stale storage.
    assign head      = mem[rd_ptr];
    assign out_data  = out_valid ? head[DWIDTH-1:0] : '0;
    assign out_class = out_valid ? head[EW-1:DWIDTH] : '0;

    assign last_col   = (col == CW'(WIDTH - 1));
    assign last_row   = (row == RW'(HEIGHT - 1));
    assign last_img   = (img_cnt == IMG_W'(NUM_IMG - 1));
    assign out_sof    = out_valid && (col == '0) && (row == '0);
    assign out_eol    = out_valid && last_col;
    assign out_eof    = out_eol && last_row;
    assign final_xfer = pop && last_col && last_row && last_img;

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (final_xfer) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {image_class, data_in};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_total <= '0;
            col      <= '0;
            row      <= '0;
            img_cnt  <= '0;
            overflow <= 1'b0;
        end else if (arm) begin
            in_total <= '0;
            col      <= '0;
            row      <= '0;
            img_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) in_total <= in_total + TW'(1);
            if ((state == S_RUN) && data_valid_in && !in_ready) overflow <= 1'b1;
            if (pop) begin
                if (last_col) begin
                    col <= '0;
                    if (last_row) begin
                        row     <= '0;
                        img_cnt <= img_cnt + IMG_W'(1);
                    end else begin
                        row <= row + RW'(1);
                    end
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_frame_scheduler.sv
// tb/tb_stream_frame_scheduler.sv - directed bench for stream_frame_scheduler with a beat-log model
// Instance 0: 4x2 frames, 2 images, depth 4. Instance 1: 1x1 frames, 3 images, depth 4.
module tb_stream_frame_scheduler;

    logic        clk = 1'b0;
    logic        reset [2];
    logic        start [2];
    logic [31:0] data_in [2];
    logic [3:0]  image_class [2];
    logic        data_valid_in [2];
    logic        in_ready [2];
    logic [31:0] out_data [2];
    logic [3:0]  out_class [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic        out_sof [2];
    logic        out_eol [2];
    logic        out_eof [2];
    logic        busy [2];
    logic        done [2];
    logic        overflow [2];
    logic [1:0]  img_cnt [2];

    always #5 clk = ~clk;

    stream_frame_scheduler #(.DWIDTH(32), .CLS_W(4), .WIDTH(4), .HEIGHT(2), .NUM_IMG(2), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .reset(reset[0]), .start(start[0]), .data_in(data_in[0]),
        .image_class(image_class[0]), .data_valid_in(data_valid_in[0]), .in_ready(in_ready[0]),
        .out_data(out_data[0]), .out_class(out_class[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_sof(out_sof[0]), .out_eol(out_eol[0]), .out_eof(out_eof[0]),
        .busy(busy[0]), .done(done[0]), .overflow(overflow[0]), .img_cnt(img_cnt[0])
    );

    stream_frame_scheduler #(.DWIDTH(32), .CLS_W(4), .WIDTH(1), .HEIGHT(1), .NUM_IMG(3), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .reset(reset[1]), .start(start[1]), .data_in(data_in[1]),
        .image_class(image_class[1]), .data_valid_in(data_valid_in[1]), .in_ready(in_ready[1]),
        .out_data(out_data[1]), .out_class(out_class[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_sof(out_sof[1]), .out_eol(out_eol[1]), .out_eof(out_eof[1]),
        .busy(busy[1]), .done(done[1]), .overflow(overflow[1]), .img_cnt(img_cnt[1])
    );

    function automatic int mw(int i); return (i == 0) ? 4 : 1; endfunction
    function automatic int mh(int i); return (i == 0) ? 2 : 1; endfunction
    function automatic int mn(int i); return (i == 0) ? 2 : 3; endfunction
    function automatic int md(int i); return 4; endfunction

    // Model: every accepted beat is appended to a log; the head is the oldest not yet transferred.
    int          mst [2];   // 0 idle, 1 run, 2 done
    int          ptot [2];
    int          opos [2];
    int          mimg [2];
    bit          movf [2];
    logic [35:0] mlog [2][64];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int  sz, tot;
            bit  rdy, psh, pp;
            tot = mn(i) * mw(i) * mh(i);
            if (reset[i]) begin
                mst[i] = 0; ptot[i] = 0; opos[i] = 0; mimg[i] = 0; movf[i] = 0;
            end else begin
                sz  = ptot[i] - opos[i];
                rdy = (mst[i] == 1) && (sz < md(i)) && (ptot[i] < tot);
                psh = data_valid_in[i] && rdy;
                pp  = (sz > 0) && out_ready[i];
                if (mst[i] == 1 && data_valid_in[i] && !rdy) movf[i] = 1;
                if (psh) begin
                    mlog[i][ptot[i]] = {image_class[i], data_in[i]};
                    ptot[i]++;
                end
                if (pp) begin
                    opos[i]++;
                    if (opos[i] % (mw(i) * mh(i)) == 0) mimg[i]++;
                end
                case (mst[i])
                    0: if (start[i]) begin
                        mst[i] = 1; ptot[i] = 0; opos[i] = 0; mimg[i] = 0; movf[i] = 0;
                    end
                    1: if (pp && opos[i] == tot) mst[i] = 2;
                    default: mst[i] = 0;
                endcase
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int xfer_cnt [2] = '{0, 0};
    int eof_cnt [2]  = '{0, 0};
    int done_cnt [2] = '{0, 0};
    logic [15:0] sof_mask = '0, eol_mask = '0, eof_mask = '0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            int          sz, fr, pos, tot;
            bit          ev;
            logic [35:0] hd;
            tot = mn(i) * mw(i) * mh(i);
            fr  = mw(i) * mh(i);
            sz  = ptot[i] - opos[i];
            ev  = sz > 0;
            hd  = ev ? mlog[i][opos[i]] : 36'h0;
            pos = opos[i] % fr;
            chk($sformatf("i%0d_in_ready", i), in_ready[i], (mst[i] == 1) && (sz < md(i)) && (ptot[i] < tot));
            chk($sformatf("i%0d_out_valid", i), out_valid[i], ev);
            chk($sformatf("i%0d_out_data", i), out_data[i], hd[31:0]);
            chk($sformatf("i%0d_out_class", i), out_class[i], hd[35:32]);
            chk($sformatf("i%0d_sof", i), out_sof[i], ev && pos == 0);
            chk($sformatf("i%0d_eol", i), out_eol[i], ev && (opos[i] % mw(i)) == mw(i) - 1);
            chk($sformatf("i%0d_eof", i), out_eof[i], ev && pos == fr - 1);
            chk($sformatf("i%0d_busy", i), busy[i], mst[i] == 1);
            chk($sformatf("i%0d_done", i), done[i], mst[i] == 2);
            chk($sformatf("i%0d_overflow", i), overflow[i], movf[i]);
            chk($sformatf("i%0d_img_cnt", i), img_cnt[i], mimg[i]);
            if (out_valid[i] && out_ready[i]) begin
                xfer_cnt[i]++;
                if (out_eof[i]) eof_cnt[i]++;
                if (i == 0 && out_data[0] < 16) begin
                    sof_mask[out_data[0][3:0]] = out_sof[0];
                    eol_mask[out_data[0][3:0]] = out_eol[0];
                    eof_mask[out_data[0][3:0]] = out_eof[0];
                end
            end
            if (done[i]) done_cnt[i]++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(int i, int budget);
        int n = 0;
        while (!done[i] && n < budget) begin
            tick();
            n++;
        end
        chk($sformatf("i%0d_done_seen", i), done[i], 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, n, d0, e0, x0;
        for (int i = 0; i < 2; i++) begin
            reset[i] = 1; start[i] = 0; data_in[i] = 0; image_class[i] = 0;
            data_valid_in[i] = 0; out_ready[i] = 0;
        end
        tick(); tick();
        chk("reset_in_ready", in_ready[0], 0);
        chk("reset_img_cnt", img_cnt[0], 0);
        reset[0] = 0; reset[1] = 0;
        tick();

        // Back-to-back beats with a free-running consumer.
        out_ready[0] = 1; image_class[0] = 3;
        start[0] = 1; tick(); start[0] = 0;
        data_valid_in[0] = 1;
        for (int i = 0; i < 16; i++) begin
            data_in[0] = i;
            tick();
        end
        data_valid_in[0] = 0;
        tick();
        chk("t1_done", done[0], 1);
        chk("t1_img_cnt", img_cnt[0], 2);
        tick(); tick();
        chk("t1_sof_mask", sof_mask, 16'h0101);
        chk("t1_eol_mask", eol_mask, 16'h8888);
        chk("t1_eof_mask", eof_mask, 16'h8080);
        chk("t1_done_count", done_cnt[0], 1);

        // Stalled consumer: FIFO fills after 4 beats, the rest are dropped.
        out_ready[0] = 0;
        start[0] = 1; tick(); start[0] = 0;
        data_valid_in[0] = 1;
        for (int i = 0; i < 6; i++) begin
            data_in[0] = 100 + i;
            tick();
        end
        data_valid_in[0] = 0;
        chk("t2_in_ready", in_ready[0], 0);
        chk("t2_overflow", overflow[0], 1);
        chk("t2_head", out_data[0], 100);
        out_ready[0] = 1;
        for (int i = 0; i < 5; i++) tick();
        chk("t2_drained", out_valid[0], 0);
        reset[0] = 1; tick(); tick(); reset[0] = 0; tick();

        // Random consumer stalls; producer only offers when accepted.
        d0 = done_cnt[0]; e0 = eof_cnt[0]; x0 = xfer_cnt[0];
        start[0] = 1; tick(); start[0] = 0;
        k = 0; n = 0;
        while (!done[0] && n < 400) begin
            out_ready[0] = 1'($urandom_range(0, 1));
            data_valid_in[0] = in_ready[0] && (k < 16);
            data_in[0] = 200 + k;
            tick();
            if (data_valid_in[0]) k++;
            n++;
        end
        data_valid_in[0] = 0;
        chk("t3_done_seen", done[0], 1);
        chk("t3_overflow", overflow[0], 0);
        tick(); tick();
        chk("t3_eof_count", eof_cnt[0] - e0, 2);
        chk("t3_xfer_count", xfer_cnt[0] - x0, 16);
        chk("t3_done_count", done_cnt[0] - d0, 1);

        // Beats in IDLE are ignored; a beat past the run total is dropped.
        out_ready[0] = 1; data_valid_in[0] = 1; data_in[0] = 77;
        tick(); tick(); tick();
        chk("t4_idle_valid", out_valid[0], 0);
        chk("t4_idle_overflow", overflow[0], 0);
        data_valid_in[0] = 0;
        start[0] = 1; tick(); start[0] = 0;
        k = 0; n = 0;
        while (k < 16 && n < 200) begin
            out_ready[0] = (k < 14);
            data_valid_in[0] = in_ready[0];
            data_in[0] = 400 + k;
            tick();
            if (data_valid_in[0]) k++;
            n++;
        end
        chk("t4_accepted", k, 16);
        data_valid_in[0] = 0; tick();
        data_valid_in[0] = 1; data_in[0] = 999; tick();
        data_valid_in[0] = 0;
        chk("t4_overflow", overflow[0], 1);
        out_ready[0] = 1;
        wait_done(0, 50);
        tick(); tick();

        // Reset in the middle of the first frame.
        start[0] = 1; tick(); start[0] = 0;
        data_valid_in[0] = 1;
        for (int i = 0; i < 5; i++) begin
            data_in[0] = 500 + i;
            tick();
        end
        data_valid_in[0] = 0; reset[0] = 1;
        tick();
        chk("t5_valid", out_valid[0], 0);
        chk("t5_busy", busy[0], 0);
        chk("t5_in_ready", in_ready[0], 0);
        chk("t5_data", out_data[0], 0);
        reset[0] = 0; tick();
        start[0] = 1; tick(); start[0] = 0;
        data_valid_in[0] = 1;
        for (int i = 0; i < 16; i++) begin
            data_in[0] = 300 + i;
            tick();
            if (i == 0) begin
                chk("t5_first_sof", out_sof[0], 1);
                chk("t5_first_data", out_data[0], 300);
            end
        end
        data_valid_in[0] = 0;
        wait_done(0, 20);
        tick();

        // Single-pixel frames: every beat is start, end of row and end of frame.
        out_ready[1] = 1; image_class[1] = 5;
        start[1] = 1; tick(); start[1] = 0;
        data_valid_in[1] = 1;
        for (int i = 0; i < 3; i++) begin
            data_in[1] = 50 + i;
            tick();
            chk("t6_valid", out_valid[1], 1);
            chk("t6_tags", {out_sof[1], out_eol[1], out_eof[1]}, 3'b111);
        end
        data_valid_in[1] = 0;
        tick();
        chk("t6_done", done[1], 1);
        chk("t6_img_cnt", img_cnt[1], 3);
        tick();
        chk("t6_done_pulse", done[1], 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_frame_scheduler.md
Name: stream_frame_scheduler

Overview:
- Controller between the VGG16 layer output stream and any downstream consumer (DDR writer, next-layer loader, bench file writer).
- Accepts per-pixel feature data with its image class and buffers it in a small FIFO.
- Drains the FIFO under a valid/ready handshake and tags each beat with frame position (sof/eol/eof).
- Sequences NUM_IMG frames of WIDTH×HEIGHT, flags dropped input, and pulses done after the last pixel leaves.

Parameters:
- DWIDTH, 32, feature data width
- CLS_W, 4, image class tag width
- WIDTH, 56, pixels per row
- HEIGHT, 56, rows per frame
- NUM_IMG, 1, frames per run
- FIFO_DEPTH, 16, buffer entries; power of two, ≥2

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  arm a run (pulse)
- data_in  in  DWIDTH  input pixel
- image_class  in  CLS_W  class tag accompanying data_in
- data_valid_in  in  1  input beat valid
- in_ready  out  1  scheduler can accept a beat
- out_data  out  DWIDTH  FIFO head data
- out_class  out  CLS_W  FIFO head class tag
- out_valid  out  1  head valid
- out_ready  in  1  consumer accepts head
- out_sof  out  1  head is pixel (0,0) of a frame
- out_eol  out  1  head is last pixel of a row
- out_eof  out  1  head is last pixel of a frame
- busy  out  1  state is RUN
- done  out  1  one-cycle pulse: run complete
- overflow  out  1  sticky: a beat was dropped during RUN
- img_cnt  out  clog2(NUM_IMG+1)  frames fully drained this run

Behaviour:
- Reset (any cycle, including mid-frame):
  - State goes to IDLE; FIFO is emptied; all counters are 0.
  - Outputs: in_ready=0, out_valid=0, out_data=0, out_class=0, sof/eol/eof=0, busy=0, done=0, overflow=0, img_cnt=0.
- States:
  - IDLE: start → RUN. Entering RUN clears the input counter, output counters, img_cnt and overflow. All input is ignored, with no overflow.
  - RUN: start is ignored. The last output transfer of the last frame → DONE.
  - DONE: lasts exactly one cycle with done=1, then → IDLE. Input is ignored.
- Input side:
  - in_ready = (state==RUN) && FIFO not full && in_total < NUM_IMG*WIDTH*HEIGHT.
  - Push occurs when data_valid_in && in_ready; {image_class, data_in} are written together.
  - In RUN, data_valid_in && !in_ready drops the beat and sets overflow. overflow stays set until reset or the next start.
- FIFO:
  - Registered storage with separate rd/wr pointers and a count of width clog2(FIFO_DEPTH)+1.
  - Pointers wrap modulo FIFO_DEPTH.
  - A beat pushed at edge N is visible at the head (out_valid=1) after edge N.
  - Push and pop in the same cycle: count is unchanged and both pointers advance. Legal whenever 0 < count < FIFO_DEPTH.
  - No bypass when empty; no push when full.
- Output side:
  - out_valid = FIFO not empty; out_data/out_class = head entry. Both are zero when empty.
  - Transfer occurs when out_valid && out_ready. out_data must hold stable while out_valid && !out_ready.
- Output counters col (0..WIDTH-1), row (0..HEIGHT-1) and img advance only on transfer:
  - col wraps to 0 and increments row.
  - Row wrap increments img and img_cnt.
  - img==NUM_IMG-1 with eof → DONE.
- Tags are combinational from the counters, gated by out_valid:
  - sof = col==0 && row==0
  - eol = col==WIDTH-1
  - eof = eol && row==HEIGHT-1
- WIDTH=1 or HEIGHT=1 must work: sof, eol and eof may coincide.
- done asserts the cycle after the final transfer. img_cnt=NUM_IMG at that point and holds through IDLE until the next start or reset.

Test Plan:
- Params WIDTH=4, HEIGHT=2, NUM_IMG=2, FIFO_DEPTH=4, out_ready=1. start, then 16 consecutive beats, data=i, class=3.
  - Outputs 0..15 appear in order, each one cycle after acceptance.
  - sof on 0 and 8; eol on 3, 7, 11, 15; eof on 7 and 15.
  - done pulses 1 cycle after beat 15; img_cnt=2.
- Same params, out_ready=0, 6 input beats.
  - in_ready drops after 4 beats; beats 5–6 are dropped and overflow=1.
  - Raising out_ready drains 0,1,2,3 in order.
- Random out_ready (50%) with continuous input: no data loss, no overflow, order preserved, eof count=2, exactly one done.
- Beats and start in IDLE before start: no push, overflow stays 0. A 17th beat after 16 accepted in RUN is dropped and sets overflow.
- Reset asserted mid-frame (after 5 pixels):
  - Next cycle all outputs are at reset values and the FIFO is empty.
  - A new start plus 16 beats completes normally with sof on the first beat.
- WIDTH=1, HEIGHT=1, NUM_IMG=3: every beat has sof=eol=eof=1; done after the 3rd transfer.
